// File: rtl/redwine_mlp_seq.sv
// RedWine 11-2-6 MLP classifier, sequential form: one shared signed MAC steps through
// all 34 products (22 layer-0, 12 layer-1), then a 5-step serial argmax.
module redwine_mlp_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [43:0]  inp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [119:0] predo,
  output logic [2:0]   out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_L0   = 3'd1;
  localparam logic [2:0] S_L1   = 3'd2;
  localparam logic [2:0] S_ARG  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic signed [7:0] l0_w(input logic j, input logic [3:0] k);
    logic signed [7:0] w;
    if (j) begin
      case (k)
        4'd0:    w = -8'sd23;
        4'd1:    w = 8'sd0;
        4'd2:    w = -8'sd3;
        4'd3:    w = -8'sd19;
        4'd4:    w = 8'sd6;
        4'd5:    w = -8'sd3;
        4'd6:    w = 8'sd28;
        4'd7:    w = 8'sd26;
        4'd8:    w = -8'sd13;
        4'd9:    w = -8'sd23;
        4'd10:   w = -8'sd17;
        default: w = 8'sd0;
      endcase
    end else begin
      case (k)
        4'd0:    w = -8'sd13;
        4'd1:    w = -8'sd68;
        4'd2:    w = -8'sd26;
        4'd3:    w = -8'sd23;
        4'd4:    w = -8'sd17;
        4'd5:    w = 8'sd15;
        4'd6:    w = -8'sd8;
        4'd7:    w = 8'sd30;
        4'd8:    w = -8'sd24;
        4'd9:    w = 8'sd15;
        4'd10:   w = 8'sd46;
        default: w = 8'sd0;
      endcase
    end
    return w;
  endfunction

  function automatic logic signed [19:0] l0_bias(input logic j);
    logic signed [19:0] b;
    if (j) begin
      b = 20'sd342;
    end else begin
      b = 20'sd468;
    end
    return b;
  endfunction

  function automatic logic signed [7:0] l1_w(input logic [2:0] m, input logic sel);
    logic signed [7:0] w;
    case ({m, sel})
      4'd0:    w = -8'sd75;
      4'd1:    w = 8'sd1;
      4'd2:    w = -8'sd19;
      4'd3:    w = 8'sd10;
      4'd4:    w = 8'sd2;
      4'd5:    w = 8'sd51;
      4'd6:    w = 8'sd18;
      4'd7:    w = 8'sd17;
      4'd8:    w = 8'sd30;
      4'd9:    w = -8'sd24;
      4'd10:   w = 8'sd25;
      4'd11:   w = -8'sd55;
      default: w = 8'sd0;
    endcase
    return w;
  endfunction

  function automatic logic signed [19:0] l1_bias(input logic [2:0] m);
    logic signed [19:0] b;
    case (m)
      3'd0:    b = 20'sd5452;
      3'd1:    b = 20'sd4388;
      3'd2:    b = 20'sd1284;
      3'd3:    b = 20'sd4148;
      3'd4:    b = 20'sd350;
      3'd5:    b = -20'sd5639;
      default: b = 20'sd0;
    endcase
    return b;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [43:0]      inp_q, inp_d;
  logic [19:0]      acc_q, acc_d;
  logic [11:0]      h0_q, h0_d, h1_q, h1_d;
  logic [5:0][18:0] n1_q, n1_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       neu_q, neu_d;
  logic [18:0]      best_val_q, best_val_d;
  logic [2:0]       best_idx_q, best_idx_d;
  logic [2:0]       out_q, out_d;

  logic [3:0]         feat_s;
  logic signed [12:0] mac_a_s;
  logic signed [7:0]  mac_w_s;
  logic signed [19:0] prod_s;
  logic [19:0]        sum_s;
  logic [18:0]        arg_cur_s;
  logic               arg_take_s;

  assign feat_s     = inp_q[{cnt_q, 2'b00} +: 4];
  assign prod_s     = 20'(mac_a_s) * 20'(mac_w_s);
  assign sum_s      = acc_q + prod_s;
  assign arg_cur_s  = n1_q[cnt_q[2:0]];
  assign arg_take_s = (arg_cur_s >= best_val_q);

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign predo     = {n1_q[0], n1_q[1], n1_q[2], n1_q[3], n1_q[4], n1_q[5]};

  // Operand selection for the shared MAC: zero-extended feature in L0, hidden value in L1.
  always_comb begin
    mac_a_s = 13'sd0;
    mac_w_s = 8'sd0;
    if (state_q == S_L1) begin
      mac_a_s = {1'b0, (cnt_q[0] ? h1_q : h0_q)};
      mac_w_s = l1_w(neu_q, cnt_q[0]);
    end else begin
      mac_a_s = {9'd0, feat_s};
      mac_w_s = l0_w(neu_q[0], cnt_q);
    end
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    inp_d      = inp_q;
    acc_d      = acc_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    n1_d       = n1_q;
    cnt_d      = cnt_q;
    neu_d      = neu_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    out_d      = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          inp_d   = inp;
          acc_d   = l0_bias(1'b0);
          cnt_d   = 4'd0;
          neu_d   = 3'd0;
          state_d = S_L0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L0: begin
        // Layer-0 accumulator is 13-bit; keep it sign-extended so the 20-bit adder wraps correctly.
        if (cnt_q == 4'd10) begin
          cnt_d = 4'd0;
          if (neu_q[0]) begin
            h1_d    = sum_s[12] ? 12'd0 : sum_s[11:0];
            acc_d   = l1_bias(3'd0);
            neu_d   = 3'd0;
            state_d = S_L1;
          end else begin
            h0_d  = sum_s[12] ? 12'd0 : sum_s[11:0];
            acc_d = l0_bias(1'b1);
            neu_d = 3'd1;
          end
        end else begin
          acc_d = {{7{sum_s[12]}}, sum_s[12:0]};
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_L1: begin
        if (cnt_q[0]) begin
          n1_d[neu_q] = sum_s[19] ? 19'd0 : sum_s[18:0];
          if (neu_q == 3'd5) begin
            cnt_d      = 4'd1;
            best_val_d = n1_q[0];
            best_idx_d = 3'd0;
            state_d    = S_ARG;
          end else begin
            cnt_d = 4'd0;
            neu_d = neu_q + 3'd1;
            acc_d = l1_bias(neu_q + 3'd1);
          end
        end else begin
          acc_d = sum_s;
          cnt_d = 4'd1;
        end
      end
      S_ARG: begin
        // >= lets a later equal score win, giving the highest-index tie rule.
        if (arg_take_s) begin
          best_val_d = arg_cur_s;
          best_idx_d = cnt_q[2:0];
        end else begin
          best_val_d = best_val_q;
        end
        if (cnt_q == 4'd5) begin
          out_d   = arg_take_s ? cnt_q[2:0] : best_idx_q;
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inp_q      <= 44'd0;
      acc_q      <= 20'd0;
      h0_q       <= 12'd0;
      h1_q       <= 12'd0;
      n1_q       <= '0;
      cnt_q      <= 4'd0;
      neu_q      <= 3'd0;
      best_val_q <= 19'd0;
      best_idx_q <= 3'd0;
      out_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      inp_q      <= inp_d;
      acc_q      <= acc_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      n1_q       <= n1_d;
      cnt_q      <= cnt_d;
      neu_q      <= neu_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_redwine_mlp_seq.sv
// Scoreboard bench for redwine_mlp_seq: expected results are queued at accept and
// popped by an independent monitor on each output handshake.
module tb_redwine_mlp_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [43:0]  inp;
  logic         out_valid;
  logic         out_ready;
  logic [119:0] predo;
  logic [2:0]   out;

  always #5 clk = ~clk;

  redwine_mlp_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready), .predo(predo), .out(out)
  );

  int W0 [2][11] = '{'{-13, -68, -26, -23, -17, 15, -8, 30, -24, 15, 46},
                     '{-23, 0, -3, -19, 6, -3, 28, 26, -13, -23, -17}};
  int B0 [2]     = '{468, 342};
  int W1 [6][2]  = '{'{-75, 1}, '{-19, 10}, '{2, 51}, '{18, 17}, '{30, -24}, '{25, -55}};
  int B1 [6]     = '{5452, 4388, 1284, 4148, 350, -5639};

  typedef struct {
    logic [2:0]   o;
    logic [119:0] p;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, modular wrap applied once per neuron.
  function automatic void model(input logic [43:0] v, output logic [2:0] o, output logic [119:0] p);
    int h[2];
    int n[6];
    int s;
    int mx;
    for (int j = 0; j < 2; j++) begin
      s = B0[j];
      for (int k = 0; k < 11; k++) s += int'(v[4*k +: 4]) * W0[j][k];
      s = s & 32'h1FFF;
      if (s >= 4096) s -= 8192;
      h[j] = (s < 0) ? 0 : s;
    end
    for (int m = 0; m < 6; m++) begin
      s = B1[m] + W1[m][0] * h[0] + W1[m][1] * h[1];
      s = s & 32'hFFFFF;
      if (s >= 524288) s -= 1048576;
      n[m] = (s < 0) ? 0 : s;
    end
    mx = n[0];
    for (int m = 1; m < 6; m++) if (n[m] > mx) mx = n[m];
    o = 3'd0;
    for (int m = 0; m < 6; m++) if (n[m] == mx) o = 3'(m);
    p = {19'(n[0]), 19'(n[1]), 19'(n[2]), 19'(n[3]), 19'(n[4]), 19'(n[5])};
  endfunction

  // Monitor: latency on rising out_valid, result compare on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (sbq.size() > 0) chk("latency", 128'(cyc - sbq[0].acc), 128'd39);
        else chk("spurious_valid", 128'(out_valid), 128'd0);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("out", 128'(out), 128'(mon_e.o));
          chk("predo", 128'(predo), 128'(mon_e.p));
        end else begin
          chk("unexpected_result", 128'(sbq.size()), 128'd1);
        end
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [43:0] v, input bit push, input logic [2:0] eo, input logic [119:0] ep);
    int   waited = 0;
    exp_t e;
    in_valid = 1'b1;
    inp      = v;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      inp      = {12'($urandom), $urandom};
      if (push) begin
        e.o   = eo;
        e.p   = ep;
        e.acc = cyc;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() > 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_empty", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0]  v;
    logic [2:0]   eo;
    logic [119:0] ep;
    logic [119:0] p_zero;
    int           w;

    rst = 1'b1; in_valid = 1'b0; inp = 44'd0; out_ready = 1'b1;
    p_zero = {19'd0, 19'd0, 19'd19662, 19'd18386, 19'd6182, 19'd0};
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out", 128'(out), 128'd0);
    chk("rst_predo", 128'(predo), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Directed vectors with hand-derived results.
    send(44'd0, 1'b1, 3'd2, p_zero);
    send(44'hFFF_FFFF_FFFF, 1'b1, 3'd0,
         {19'd5452, 19'd4388, 19'd1284, 19'd4148, 19'd350, 19'd0});
    send(44'hF00_0000_0000, 1'b1, 3'd4,
         {19'd0, 19'd0, 19'd8037, 19'd26471, 19'd33002, 19'd18526});
    drain();

    // Backpressure: hold DONE, poke in_valid, then release.
    out_ready = 1'b0;
    v = {12'($urandom), $urandom};
    model(v, eo, ep);
    send(v, 1'b1, eo, ep);
    w = 0;
    while (!out_valid && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      inp = {12'($urandom), $urandom};
      @(posedge clk); #1;
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_out", 128'(out), 128'(eo));
      chk("bp_hold_predo", 128'(predo), 128'(ep));
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_reaccept", 128'(in_ready), 128'd1);
    drain();

    // Reset in the middle of layer 0.
    send(44'h123_4567_89AB, 1'b0, 3'd0, 120'd0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    chk("midrst_predo", 128'(predo), 128'd0);
    chk("midrst_out", 128'(out), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_rel_ready", 128'(in_ready), 128'd1);
    chk("midrst_rel_valid", 128'(out_valid), 128'd0);
    send(44'd0, 1'b1, 3'd2, p_zero);
    drain();

    // Randomized vectors against the reference model.
    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0: for (int k = 0; k < 11; k++) v[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
        default: v = {12'($urandom), $urandom};
      endcase
      model(v, eo, ep);
      send(v, 1'b1, eo, ep);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
